pll_test_supervisor: RTL

- Parametrised successor to the PLL-lock reset gating at the top of the test design.
- Runs on the PLL output clock.
- Qualifies the PLL lock signal, sequences the reset release of NUM_CH cb_seg test cores with a configurable stagger, and launches and collects multi-channel test runs.
- Provides aggregate pass, done and lock-loss status for pins and the logic analyzer.

---
 rtl/pll_test_sup_pkg.sv | 32 +++
 rtl/pll_test_supervisor_sync_bit.sv | 29 ++
 rtl/pll_test_supervisor.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_test_sup_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_test_sup_pkg
// Description : Shared state encoding, width helper and limits for the
//               PLL test supervisor.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_test_sup_pkg;

    localparam int MAX_CH = 8;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        HOLD      = 3'd1,
        RELEASE   = 3'd2,
        IDLE      = 3'd3,
        RUN       = 3'd4,
        DONE      = 3'd5
    } sup_state_t;

    // Bits needed to represent 0 .. value-1 (never less than 1).
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pll_test_supervisor_sync_bit.sv
`default_nettype none
// ============================================================================
// Module      : sync_bit
// Description : Multi-stage single-bit synchroniser, asynchronous reset to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pll_test_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : pll_test_supervisor
// Description : Qualifies PLL lock, staggers per-channel core reset release,
//               launches/collects multi-channel test runs.
//               Optional run timeout: define PLL_TEST_SUPERVISOR_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_test_supervisor
    import pll_test_sup_pkg::*;
#(
    parameter int NUM_CH             = 2,
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 16,
    parameter int RST_HOLD_CYCLES    = 8,
    parameter int STAGGER_CYCLES     = 4,
    parameter int RUN_CNT_W          = 8
`ifdef PLL_TEST_SUPERVISOR_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES     = 65535
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 locked,
    input  logic                 test_start,
    input  logic [NUM_CH-1:0]    ch_test_end,
    input  logic [NUM_CH-1:0]    ch_test_good,
    output logic [NUM_CH-1:0]    ch_reset,
    output logic [NUM_CH-1:0]    ch_test_start,
    output logic                 pass,
    output logic                 done,
    output logic                 lock_lost,
    output logic [RUN_CNT_W-1:0] run_count
`ifdef PLL_TEST_SUPERVISOR_TIMEOUT_EN
    ,
    output logic                 timeout
`endif
);

    localparam int c_stable_w = clog2(LOCK_STABLE_CYCLES + 1);
    localparam int c_hold_w   = clog2(RST_HOLD_CYCLES + 1);
    localparam int c_rel_w    = clog2(STAGGER_CYCLES * (NUM_CH - 1) + 2);
`ifdef PLL_TEST_SUPERVISOR_TIMEOUT_EN
    localparam int c_to_w     = clog2(TIMEOUT_CYCLES + 1);
`endif

    logic w_locked_s;
    logic w_start_s;

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_locked (
        .clk (clk),
        .rst (reset),
        .i_d (locked),
        .o_q (w_locked_s)
    );

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_start (
        .clk (clk),
        .rst (reset),
        .i_d (test_start),
        .o_q (w_start_s)
    );

    sup_state_t              r_state,         w_state_nxt;
    logic [c_stable_w-1:0]   r_stable_cnt,    w_stable_nxt;
    logic [c_hold_w-1:0]     r_hold_cnt,      w_hold_nxt;
    logic [c_rel_w-1:0]      r_rel_cnt,       w_rel_nxt;
    logic [NUM_CH-1:0]       r_ch_reset,      w_ch_reset_nxt;
    logic [NUM_CH-1:0]       r_ch_test_start, w_ch_start_nxt;
    logic [NUM_CH-1:0]       r_end_l,         w_end_nxt;
    logic [NUM_CH-1:0]       r_good_l,        w_good_nxt;
    logic                    r_done,          w_done_nxt;
    logic                    r_pass,          w_pass_nxt;
    logic                    r_lock_lost,     w_lost_nxt;
    logic [RUN_CNT_W-1:0]    r_run_count,     w_run_cnt_nxt;
    logic                    r_start_prev;
`ifdef PLL_TEST_SUPERVISOR_TIMEOUT_EN
    logic [c_to_w-1:0]       r_to_cnt,        w_to_cnt_nxt;
    logic                    r_timeout,       w_timeout_nxt;
`endif

    logic                    w_start_rise;
    logic                    w_start_run;
    logic                    w_lose_lock;
    logic [RUN_CNT_W-1:0]    w_run_cnt_inc;
    logic [NUM_CH-1:0]       w_entry_mask;
    logic [NUM_CH-1:0]       w_step_mask;

    assign w_start_rise  = w_start_s & ~r_start_prev;
    assign w_run_cnt_inc = (r_run_count == '1) ? r_run_count
                                               : r_run_count + RUN_CNT_W'(1);

    always_comb begin
        w_state_nxt    = r_state;
        w_stable_nxt   = r_stable_cnt;
        w_hold_nxt     = r_hold_cnt;
        w_rel_nxt      = r_rel_cnt;
        w_ch_reset_nxt = r_ch_reset;
        w_ch_start_nxt = r_ch_test_start;
        w_end_nxt      = r_end_l;
        w_good_nxt     = r_good_l;
        w_done_nxt     = r_done;
        w_pass_nxt     = r_pass;
        w_lost_nxt     = r_lock_lost;
        w_run_cnt_nxt  = r_run_count;
`ifdef PLL_TEST_SUPERVISOR_TIMEOUT_EN
        w_to_cnt_nxt   = r_to_cnt;
        w_timeout_nxt  = r_timeout;
`endif
        w_start_run    = 1'b0;
        w_lose_lock    = 1'b0;

        // A channel stays in reset while the release counter is below its slot.
        for (int i = 0; i < NUM_CH; i++) begin
            w_entry_mask[i] = (STAGGER_CYCLES * i) > 0;
            w_step_mask[i]  = (int'(r_rel_cnt) + 1) < (STAGGER_CYCLES * i);
        end

        case (r_state)
            WAIT_LOCK: begin
                if (!w_locked_s) begin
                    w_stable_nxt = '0;
                end else if (r_stable_cnt == c_stable_w'(LOCK_STABLE_CYCLES - 1)) begin
                    w_stable_nxt = '0;
                    w_hold_nxt   = '0;
                    if (RST_HOLD_CYCLES == 0) begin
                        w_state_nxt    = RELEASE;
                        w_rel_nxt      = '0;
                        w_ch_reset_nxt = w_entry_mask;
                    end else begin
                        w_state_nxt = HOLD;
                    end
                end else begin
                    w_stable_nxt = r_stable_cnt + c_stable_w'(1);
                end
            end
            HOLD: begin
                if (!w_locked_s) begin
                    w_lose_lock = 1'b1;
                end else if (r_hold_cnt == c_hold_w'(RST_HOLD_CYCLES - 1)) begin
                    w_state_nxt    = RELEASE;
                    w_rel_nxt      = '0;
                    w_ch_reset_nxt = w_entry_mask;
                end else begin
                    w_hold_nxt = r_hold_cnt + c_hold_w'(1);
                end
            end
            RELEASE: begin
                if (!w_locked_s) begin
                    w_lose_lock = 1'b1;
                end else begin
                    w_rel_nxt      = r_rel_cnt + c_rel_w'(1);
                    w_ch_reset_nxt = r_ch_reset & w_step_mask;
                    if ((r_ch_reset & w_step_mask) == '0) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            IDLE, DONE: begin
                if (!w_locked_s) begin
                    w_lose_lock = 1'b1;
                end else if (w_start_rise) begin
                    w_start_run = 1'b1;
                end
            end
            RUN: begin
                if (!w_locked_s) begin
                    w_lose_lock = 1'b1;
                end else if (&r_end_l) begin
                    w_state_nxt    = DONE;
                    w_done_nxt     = 1'b1;
                    w_pass_nxt     = &r_good_l;
                    w_ch_start_nxt = '0;
                    w_run_cnt_nxt  = w_run_cnt_inc;
                end else begin
                    // Result is captured only on a channel's first end pulse.
                    w_end_nxt  = r_end_l | ch_test_end;
                    w_good_nxt = r_good_l | (ch_test_good & ch_test_end & ~r_end_l);
`ifdef PLL_TEST_SUPERVISOR_TIMEOUT_EN
                    if (r_to_cnt == c_to_w'(TIMEOUT_CYCLES - 1)) begin
                        w_state_nxt    = DONE;
                        w_done_nxt     = 1'b1;
                        w_pass_nxt     = 1'b0;
                        w_timeout_nxt  = 1'b1;
                        w_ch_start_nxt = '0;
                        w_run_cnt_nxt  = w_run_cnt_inc;
                    end else begin
                        w_to_cnt_nxt = r_to_cnt + c_to_w'(1);
                    end
`endif
                end
            end
            default: begin
                w_state_nxt = WAIT_LOCK;
            end
        endcase

        if (w_lose_lock) begin
            w_state_nxt    = WAIT_LOCK;
            w_stable_nxt   = '0;
            w_ch_reset_nxt = '1;
            w_ch_start_nxt = '0;
            w_done_nxt     = 1'b0;
            w_pass_nxt     = 1'b0;
            w_lost_nxt     = 1'b1;
        end

        if (w_start_run) begin
            w_state_nxt    = RUN;
            w_end_nxt      = '0;
            w_good_nxt     = '0;
            w_done_nxt     = 1'b0;
            w_pass_nxt     = 1'b0;
            w_ch_start_nxt = '1;
`ifdef PLL_TEST_SUPERVISOR_TIMEOUT_EN
            w_to_cnt_nxt   = '0;
            w_timeout_nxt  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= WAIT_LOCK;
            r_stable_cnt    <= '0;
            r_hold_cnt      <= '0;
            r_rel_cnt       <= '0;
            r_ch_reset      <= '1;
            r_ch_test_start <= '0;
            r_end_l         <= '0;
            r_good_l        <= '0;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
            r_lock_lost     <= 1'b0;
            r_run_count     <= '0;
            r_start_prev    <= 1'b0;
`ifdef PLL_TEST_SUPERVISOR_TIMEOUT_EN
            r_to_cnt        <= '0;
            r_timeout       <= 1'b0;
`endif
        end else begin
            r_state         <= w_state_nxt;
            r_stable_cnt    <= w_stable_nxt;
            r_hold_cnt      <= w_hold_nxt;
            r_rel_cnt       <= w_rel_nxt;
            r_ch_reset      <= w_ch_reset_nxt;
            r_ch_test_start <= w_ch_start_nxt;
            r_end_l         <= w_end_nxt;
            r_good_l        <= w_good_nxt;
            r_done          <= w_done_nxt;
            r_pass          <= w_pass_nxt;
            r_lock_lost     <= w_lost_nxt;
            r_run_count     <= w_run_cnt_nxt;
            r_start_prev    <= w_start_s;
`ifdef PLL_TEST_SUPERVISOR_TIMEOUT_EN
            r_to_cnt        <= w_to_cnt_nxt;
            r_timeout       <= w_timeout_nxt;
`endif
        end
    end

    assign ch_reset      = r_ch_reset;
    assign ch_test_start = r_ch_test_start;
    assign pass          = r_pass;
    assign done          = r_done;
    assign lock_lost     = r_lock_lost;
    assign run_count     = r_run_count;
`ifdef PLL_TEST_SUPERVISOR_TIMEOUT_EN
    assign timeout       = r_timeout;
`endif

endmodule
`default_nettype wire
